// File: rtl/ones_arb_pkg.sv
// Shared state encoding and width helpers for the ones-counter arbiter.
// Used by ones_counter_arbiter and ones_counter.
package ones_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Requester index width: never narrower than one bit, even for a single requester.
  function automatic int calc_idw(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  function automatic int calc_ow(input int features);
    return $clog2(features + 1);
  endfunction

endpackage

// File: rtl/ones_counter.sv
// Registered popcount of one feature vector.
// The result updates one clock after the input vector changes.
module ones_counter
  import ones_arb_pkg::*;
#(
  parameter int INPUT_FEATURES = 4,
  localparam int OW = calc_ow(INPUT_FEATURES)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [INPUT_FEATURES-1:0] input_features_i,
  output logic [OW-1:0]             ones_o
);

  logic [OW-1:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < INPUT_FEATURES; i++) begin
      count = count + OW'(input_features_i[i]);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ones_o <= '0;
    end else begin
      ones_o <= count;
    end
  end

endmodule

// File: rtl/ones_counter_arbiter.sv
// Round-robin arbiter that feeds one shared popcount datapath and returns tagged results.
// Define ONES_COUNTER_ARBITER_STATS_EN to add the saturating stat_served_o response counter.
module ones_counter_arbiter
  import ones_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_FEATURES = 4,
  localparam int IDW = calc_idw(NUM_REQ),
  localparam int OW  = calc_ow(INPUT_FEATURES)
) (
  input  logic                              clock_i,
  input  logic                              reset_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*INPUT_FEATURES-1:0] req_features_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic                              resp_ready_i,
  output logic                              resp_valid_o,
  output logic [IDW-1:0]                    resp_id_o,
  output logic [OW-1:0]                     resp_ones_o
`ifdef ONES_COUNTER_ARBITER_STATS_EN
  ,
  output logic [15:0]                       stat_served_o
`endif
);

  state_t                    state_q, state_d;
  logic [IDW-1:0]            last_grant_q;
  logic [IDW-1:0]            cap_id_q;
  logic [IDW-1:0]            resp_id_q;
  logic [INPUT_FEATURES-1:0] cap_feat_q;
  logic [IDW-1:0]            winner;
  logic                      any_valid;
  logic                      accept;

  // Search starts just past the last grant; the nearest valid requester wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (valid[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign any_valid = |req_valid_i;
  assign winner    = rr_pick(req_valid_i, last_grant_q);
  assign accept    = (state_q == IDLE) && any_valid;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = COUNT;
      COUNT:   state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is gated by reset so a held request never shows ready while reset is asserted.
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = (state_q == RESP);
    if ((state_q == IDLE) && reset_n_i && any_valid) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      cap_id_q     <= '0;
      cap_feat_q   <= '0;
      resp_id_q    <= '0;
    end else begin
      if (accept) begin
        cap_feat_q   <= req_features_i[int'(winner)*INPUT_FEATURES +: INPUT_FEATURES];
        cap_id_q     <= winner;
        last_grant_q <= winner;
      end
      if (state_q == COUNT) begin
        resp_id_q <= cap_id_q;
      end
    end
  end

  assign resp_id_o = resp_id_q;

  ones_counter #(
    .INPUT_FEATURES(INPUT_FEATURES)
  ) u_ones_counter (
    .clock_i         (clock_i),
    .reset_i         (~reset_n_i),
    .input_features_i(cap_feat_q),
    .ones_o          (resp_ones_o)
  );

`ifdef ONES_COUNTER_ARBITER_STATS_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_served_o <= '0;
    end else if ((state_q == RESP) && resp_ready_i && (stat_served_o != 16'hFFFF)) begin
      stat_served_o <= stat_served_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ones_counter_arbiter.sv
// Randomized self-checking bench for ones_counter_arbiter against a transaction-level model.
// Define ONES_COUNTER_ARBITER_STATS_EN to also exercise stat_served_o.
module tb_ones_counter_arbiter;

  localparam int N  = 4;
  localparam int F  = 4;
  localparam int IW = 2;
  localparam int OW = 3;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic [N-1:0]  req_valid_i;
  logic [N*F-1:0] req_features_i;
  logic [N-1:0]  req_ready_o;
  logic          resp_ready_i;
  logic          resp_valid_o;
  logic [IW-1:0] resp_id_o;
  logic [OW-1:0] resp_ones_o;
`ifdef ONES_COUNTER_ARBITER_STATS_EN
  logic [15:0]   stat_served_o;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: pointer to last granted requester and last delivered result.
  int model_last;
  int model_id;
  int model_ones;

  ones_counter_arbiter #(
    .NUM_REQ(N),
    .INPUT_FEATURES(F)
  ) dut (
    .clock_i       (clock_i),
    .reset_n_i     (reset_n_i),
    .req_valid_i   (req_valid_i),
    .req_features_i(req_features_i),
    .req_ready_o   (req_ready_o),
    .resp_ready_i  (resp_ready_i),
    .resp_valid_o  (resp_valid_o),
    .resp_id_o     (resp_id_o),
    .resp_ones_o   (resp_ones_o)
`ifdef ONES_COUNTER_ARBITER_STATS_EN
    ,
    .stat_served_o (stat_served_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  function automatic int model_winner(input logic [N-1:0] valid, input int last);
    for (int k = 1; k <= N; k++) begin
      if (valid[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic model_reset();
    model_last = N - 1;
    model_id   = 0;
    model_ones = 0;
  endtask

  // Full transaction: grant in IDLE, COUNT, then RESP held for bp cycles of backpressure.
  task automatic run_txn(input logic [N-1:0] valid, input logic [N*F-1:0] feats,
                         input int bp, input string tag);
    int w;
    int ones;
    logic [F-1:0] vec;
    w    = model_winner(valid, model_last);
    vec  = feats[w*F +: F];
    ones = $countones(vec);
    req_valid_i    = valid;
    req_features_i = feats;
    resp_ready_i   = (bp == 0);
    @(negedge clock_i);
    vectors++;
    if (req_ready_o !== N'(1 << w)) begin
      miscompares++;
      $display("[TB] FAIL %s grant: got %b expected %b", tag, req_ready_o, N'(1 << w));
    end
    vectors++;
    if ({resp_valid_o, resp_id_o, resp_ones_o} !== {1'b0, IW'(model_id), OW'(model_ones)}) begin
      miscompares++;
      $display("[TB] FAIL %s idle_hold: got v=%0b id=%0d ones=%0d expected v=0 id=%0d ones=%0d",
               tag, resp_valid_o, resp_id_o, resp_ones_o, model_id, model_ones);
    end
    step();
    @(negedge clock_i);
    vectors++;
    if ({req_ready_o, resp_valid_o} !== {N'(0), 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL %s count_phase: got ready=%b valid=%0b expected ready=0 valid=0",
               tag, req_ready_o, resp_valid_o);
    end
    step();
    for (int i = 0; i <= bp; i++) begin
      if (i == bp) resp_ready_i = 1'b1;
      @(negedge clock_i);
      vectors++;
      if ({req_ready_o, resp_valid_o, resp_id_o, resp_ones_o} !==
          {N'(0), 1'b1, IW'(w), OW'(ones)}) begin
        miscompares++;
        $display("[TB] FAIL %s resp[%0d]: got ready=%b v=%0b id=%0d ones=%0d expected ready=0 v=1 id=%0d ones=%0d",
                 tag, i, req_ready_o, resp_valid_o, resp_id_o, resp_ones_o, w, ones);
      end
      step();
    end
    model_last = w;
    model_id   = w;
    model_ones = ones;
  endtask

  task automatic test_reset();
    reset_n_i      = 1'b0;
    req_valid_i    = '0;
    req_features_i = '0;
    resp_ready_i   = 1'b0;
    model_reset();
    repeat (2) @(negedge clock_i);
    vectors++;
    if ({req_ready_o, resp_valid_o, resp_id_o, resp_ones_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got ready=%b v=%0b id=%0d ones=%0d expected all 0",
               req_ready_o, resp_valid_o, resp_id_o, resp_ones_o);
    end
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_single();
    run_txn(4'b0010, 16'h00B0, 0, "single");
  endtask

  task automatic test_back_to_back();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 16'($urandom), 0, "b2b");
      vectors++;
      if (model_id !== exp_order[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_order[%0d]: got %0d expected %0d", i, model_id, exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    run_txn(4'b0101, 16'h0E07, 5, "backpressure");
  endtask

  task automatic test_boundary();
    run_txn(4'b1000, 16'h0FFF, 0, "zero_vec_req3");
    run_txn(4'b0001, 16'h000F, 0, "ones_vec_req0");
  endtask

  task automatic test_drop();
    req_valid_i = 4'b0100;
    @(negedge clock_i);
    vectors++;
    if (req_ready_o !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL drop_offer: got %b expected 0100", req_ready_o);
    end
    #1 req_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock_i);
      vectors++;
      if ({req_ready_o, resp_valid_o} !== {N'(0), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL drop_idle[%0d]: got ready=%b v=%0b expected 0", i, req_ready_o, resp_valid_o);
      end
    end
    step();
    run_txn(4'b1111, 16'h1234, 0, "after_drop");
  endtask

  task automatic test_reset_in_count();
    req_valid_i    = 4'b0010;
    req_features_i = 16'hFFFF;
    resp_ready_i   = 1'b1;
    step();
    #2 reset_n_i = 1'b0;
    #1;
    vectors++;
    if ({req_ready_o, resp_valid_o, resp_id_o, resp_ones_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_count: got ready=%b v=%0b id=%0d ones=%0d expected all 0",
               req_ready_o, resp_valid_o, resp_id_o, resp_ones_o);
    end
    req_valid_i = '0;
    model_reset();
    @(negedge clock_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock_i);
      vectors++;
      if (resp_valid_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL no_resp_after_reset[%0d]: got %0b expected 0", i, resp_valid_o);
      end
    end
    step();
    run_txn(4'b1111, 16'h8421, 0, "first_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_txn(N'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

`ifdef ONES_COUNTER_ARBITER_STATS_EN
  task automatic test_stats();
    test_reset();
    for (int i = 0; i < 10; i++) begin
      run_txn(N'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 2), "stats");
    end
    @(negedge clock_i);
    vectors++;
    if (stat_served_o !== 16'd10) begin
      miscompares++;
      $display("[TB] FAIL stat_served: got %0d expected 10", stat_served_o);
    end
    test_reset();
    @(negedge clock_i);
    vectors++;
    if (stat_served_o !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL stat_reset: got %0d expected 0", stat_served_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_drop();
    test_reset_in_count();
    test_random();
`ifdef ONES_COUNTER_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
